// File: rtl/digit_code_converter_if.sv
// Handshake/data bundle for digit_code_converter.
//   in_valid/in_ready : word handshake toward the converter
//   din               : NDIGITS digits in 8,4,-2,-1 code, digit NDIGITS-1 is MSD
//   mode              : 0 BCD, 1 per-digit Gray, 2 binary value, 3 reserved
//   out_valid/out_ready : result handshake from the converter
//   dout/err          : converted word and invalid-code/reserved-mode flag
// master = producer/consumer side, slave = converter side.
interface digit_code_converter_if #(
  parameter int NDIGITS = 4
);
  localparam int W = 4 * NDIGITS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         err;

  modport master (
    output in_valid, din, mode, out_ready,
    input  in_ready, out_valid, dout, err
  );

  modport slave (
    input  in_valid, din, mode, out_ready,
    output in_ready, out_valid, dout, err
  );
endinterface

// File: rtl/digit_code_converter.sv
// Converts a word of NDIGITS decimal digits in 8,4,-2,-1 code into per-digit
// BCD, per-digit Gray, or the binary value of the whole number, one digit per
// cycle, MSD first.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : digit_code_converter_if.slave (in_valid/in_ready/din/mode,
//           out_valid/out_ready/dout/err)
module digit_code_converter #(
  parameter int NDIGITS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  digit_code_converter_if.slave bus
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  din_q;
  logic [1:0]    mode_q;
  logic [W-1:0]  acc_q, acc_d;
  logic          err_acc_q, err_d;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  dout_q;
  logic          err_q;
  logic [W-1:0]  result;

  logic [3:0]    cur_code;
  logic          dig_ok;
  logic [3:0]    dig_val;
  logic [3:0]    dig_out;

  // {legal, value} for one 8,4,-2,-1 digit code
  function automatic logic [4:0] decode(input logic [3:0] c);
    case (c)
      4'b0000: decode = {1'b1, 4'd0};
      4'b0111: decode = {1'b1, 4'd1};
      4'b0110: decode = {1'b1, 4'd2};
      4'b0101: decode = {1'b1, 4'd3};
      4'b0100: decode = {1'b1, 4'd4};
      4'b1011: decode = {1'b1, 4'd5};
      4'b1010: decode = {1'b1, 4'd6};
      4'b1001: decode = {1'b1, 4'd7};
      4'b1000: decode = {1'b1, 4'd8};
      4'b1111: decode = {1'b1, 4'd9};
      default: decode = {1'b0, 4'd0};
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = CONV;
      end
      CONV: begin
        if (idx_q == '0) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One conversion step on the digit selected by idx_q
  always_comb begin
    cur_code          = din_q[idx_q*4 +: 4];
    {dig_ok, dig_val} = decode(cur_code);
    dig_out           = 4'hF;
    acc_d             = acc_q;
    err_d             = err_acc_q | ~dig_ok | (mode_q == 2'd3);
    case (mode_q)
      2'd0: begin
        if (dig_ok) dig_out = dig_val;
        acc_d[idx_q*4 +: 4] = dig_out;
      end
      2'd1: begin
        if (dig_ok) dig_out = dig_val ^ (dig_val >> 1);
        acc_d[idx_q*4 +: 4] = dig_out;
      end
      2'd2: begin
        acc_d = acc_q * W'(10) + W'(dig_val);
      end
      default: acc_d = '0;
    endcase
    // Binary mode with any bad digit, and the reserved mode, report zero
    if ((mode_q == 2'd3) || ((mode_q == 2'd2) && err_d)) result = '0;
    else                                                 result = acc_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q     <= '0;
      mode_q    <= '0;
      acc_q     <= '0;
      err_acc_q <= 1'b0;
      idx_q     <= '0;
      dout_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            din_q     <= bus.din;
            mode_q    <= bus.mode;
            acc_q     <= '0;
            err_acc_q <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= IW'(NDIGITS - 1);
          end
        end
        CONV: begin
          acc_q     <= acc_d;
          err_acc_q <= err_d;
          if (idx_q == '0) begin
            dout_q <= result;
            err_q  <= err_d;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dout = dout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_digit_code_converter.sv
// Scoreboard bench for digit_code_converter with NDIGITS = 4.
module tb_digit_code_converter;

  localparam int NDIGITS = 4;
  localparam int W       = 4 * NDIGITS;

  typedef struct packed {
    logic         err;
    logic [W-1:0] dout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   cyc;

  exp_t exp_q[$];

  digit_code_converter_if #(.NDIGITS(NDIGITS)) bus ();

  digit_code_converter #(.NDIGITS(NDIGITS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference: code table lookup then per-mode composition
  function automatic exp_t model(input logic [W-1:0] d, input logic [1:0] m);
    exp_t        r;
    logic [3:0]  c, v, o;
    logic        ok;
    logic [31:0] num;
    r   = '0;
    num = 0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      c  = d[i*4 +: 4];
      ok = 1'b1;
      v  = 4'd0;
      case (c)
        4'h0: v = 4'd0;  4'h7: v = 4'd1;  4'h6: v = 4'd2;
        4'h5: v = 4'd3;  4'h4: v = 4'd4;  4'hB: v = 4'd5;
        4'hA: v = 4'd6;  4'h9: v = 4'd7;  4'h8: v = 4'd8;
        4'hF: v = 4'd9;
        default: ok = 1'b0;
      endcase
      if (!ok) r.err = 1'b1;
      o = (m == 2'd1) ? (v ^ (v >> 1)) : v;
      r.dout[i*4 +: 4] = ok ? o : 4'hF;
      num = num * 10 + v;
    end
    if (m == 2'd2) r.dout = r.err ? '0 : num[W-1:0];
    if (m == 2'd3) begin
      r.dout = '0;
      r.err  = 1'b1;
    end
    return r;
  endfunction

  task automatic send(input logic [W-1:0] d, input logic [1:0] m, input bit push);
    int unsigned t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    bus.din      = d;
    bus.mode     = m;
    if (push) exp_q.push_back(model(d, m));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.din      = W'($urandom);
    bus.mode     = 2'($urandom);
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [3:0] legal[10];
    logic [3:0] bad[6];
    logic [W-1:0] w;
    legal = '{4'h0, 4'h7, 4'h6, 4'h5, 4'h4, 4'hB, 4'hA, 4'h9, 4'h8, 4'hF};
    bad   = '{4'h1, 4'h2, 4'h3, 4'hC, 4'hD, 4'hE};
    w = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if ($urandom_range(0, 7) == 0) w[i*4 +: 4] = bad[$urandom_range(0, 5)];
      else                           w[i*4 +: 4] = legal[$urandom_range(0, 9)];
    end
    return w;
  endfunction

  // Output monitor: latency, scoreboard compare, spurious output detection
  bit   pend;
  bit   prev_ov;
  int   acc_cyc;
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      pend    = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (pend) chk("latency", 32'(cyc - acc_cyc), 32'(NDIGITS));
        else      chk("spurious_out_valid", 32'd1, 32'd0);
        pend = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("dout", 32'(bus.dout), 32'(e.dout));
          chk("err", 32'(bus.err), 32'(e.err));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        pend    = 1'b1;
        acc_cyc = cyc + 1;
      end
      prev_ov = bus.out_valid;
    end
  end

  initial begin
    logic [W-1:0] hold_dout;
    logic         hold_err;
    int unsigned  t;
    n_checks      = 0;
    n_errors      = 0;
    cyc           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.din       = 16'hFB07;
    bus.mode      = 2'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

    send(16'hFB07, 2'd0, 1'b1);
    send(16'hFB07, 2'd1, 1'b1);
    send(16'hFB07, 2'd2, 1'b1);
    send(16'hFFFF, 2'd2, 1'b1);
    send(16'h0000, 2'd2, 1'b1);
    send(16'hFB01, 2'd0, 1'b1);
    send(16'hFB01, 2'd2, 1'b1);
    send(16'h1234, 2'd3, 1'b1);
    send(16'hFB07, 2'd3, 1'b1);
    send(16'hEDC3, 2'd1, 1'b1);
    drain();
    // Anchor the model to literal expected values too
    chk("model_fb07_m1", 32'(model(16'hFB07, 2'd1).dout), 32'h0000D701);
    chk("model_fb07_m2", 32'(model(16'hFB07, 2'd2).dout), 32'h0000251D);

    for (int i = 0; i < 25; i++) send(rand_word(), 2'($urandom_range(0, 3)), 1'b1);
    drain();

    // Back-pressure in DONE
    bus.out_ready = 1'b0;
    send(16'hFB07, 2'd2, 1'b1);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("hold_reach_done", 32'(bus.out_valid), 32'd1);
    hold_dout = bus.dout;
    hold_err  = bus.err;
    chk("hold_dout_value", 32'(hold_dout), 32'h251D);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.din      = W'($urandom);
      bus.mode     = 2'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_dout", 32'(bus.dout), 32'(hold_dout));
      chk("hold_err", 32'(bus.err), 32'(hold_err));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    drain();

    // Reset on the second CONV cycle
    send(16'hFB07, 2'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_dout", 32'(bus.dout), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_output", 32'(bus.out_valid), 32'd0);
    send(16'hFB01, 2'd0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
